// File: rtl/ipv6_header_deframer_if.sv
// Stream, header and payload signals of the IPv6 header deframer.
// slave is the deframer's view; master is the surrounding environment's view.
interface ipv6_header_deframer_if #(
    parameter int WD = 32
);
    logic            in_vld;
    logic [WD-1:0]   in_bus;
    logic            in_last;
    logic            in_rdy;
    logic            hdr_vld;
    logic [319:0]    hdr_bus;
    logic            hdr_rdy;
    logic            pl_vld;
    logic [WD-1:0]   pl_bus;
    logic [WD/8-1:0] pl_keep;
    logic            pl_last;
    logic            pl_rdy;
    logic            err_version;
    logic            err_length;
    logic            err_hop;

    modport master (
        output in_vld, in_bus, in_last, hdr_rdy, pl_rdy,
        input  in_rdy, hdr_vld, hdr_bus, pl_vld, pl_bus, pl_keep, pl_last,
        input  err_version, err_length, err_hop
    );

    modport slave (
        input  in_vld, in_bus, in_last, hdr_rdy, pl_rdy,
        output in_rdy, hdr_vld, hdr_bus, pl_vld, pl_bus, pl_keep, pl_last,
        output err_version, err_length, err_hop
    );
endinterface

// File: rtl/ipv6_header_deframer.sv
// Rebuilds a 320-bit IPv6 header from WD-bit beats and forwards the payload trimmed to PayloadLength.
// IPV6_DEFRAMER_HOPLIMIT_CHECK_EN enables the HopLimit==0 drop. States: HDR collect | HOLD present header | PAYLOAD forward | DROP discard to in_last.
module ipv6_header_deframer #(
    parameter int WD = 32
) (
    input  logic clk,
    input  logic rst,
    ipv6_header_deframer_if.slave bus
);
    localparam int N  = 320 / WD;
    localparam int B  = WD / 8;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {ST_HDR, ST_HOLD, ST_PAYLOAD, ST_DROP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [16:0]    rem_q, rem_d;
    logic           lastq_q, lastq_d;
    logic [319:0]   hdr_q, hdr_d, hdr_full;
    logic           err_version_q, err_version_d;
    logic           err_length_q, err_length_d;
    logic           err_hop_q, err_hop_d;
    logic           hop_bad, rem_le_b;
    logic           in_rdy_c, pl_vld_c, pl_last_c;
    logic [B-1:0]   pl_keep_c;
    int             hdr_base;

    // Header as it will look once the current beat is stored; field checks on the final beat use it.
    always_comb begin
        hdr_base = 319 - WD * int'(cnt_q);
        hdr_full = hdr_q;
        hdr_full[hdr_base -: WD] = bus.in_bus;
    end

`ifdef IPV6_DEFRAMER_HOPLIMIT_CHECK_EN
    assign hop_bad = (hdr_full[263:256] == 8'd0);
`else
    assign hop_bad = 1'b0;
`endif

    assign rem_le_b = (rem_q <= 17'(B));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        lastq_d       = lastq_q;
        hdr_d         = hdr_q;
        err_version_d = 1'b0;
        err_length_d  = 1'b0;
        err_hop_d     = 1'b0;
        in_rdy_c      = 1'b0;
        pl_vld_c      = 1'b0;
        pl_last_c     = 1'b0;
        pl_keep_c     = '0;

        case (state_q)
            ST_HDR: begin
                in_rdy_c = 1'b1;
                if (bus.in_vld) begin
                    hdr_d = hdr_full;
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d = '0;
                        if (hdr_full[319:316] != 4'd6) begin
                            err_version_d = 1'b1;
                            state_d       = bus.in_last ? ST_HDR : ST_DROP;
                        end else if (hop_bad) begin
                            err_hop_d = 1'b1;
                            state_d   = bus.in_last ? ST_HDR : ST_DROP;
                        end else begin
                            state_d = ST_HOLD;
                            rem_d   = {1'b0, hdr_full[287:272]};
                            lastq_d = bus.in_last;
                        end
                    end else if (bus.in_last) begin
                        err_length_d = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (bus.hdr_rdy) begin
                    if (hdr_q[287:272] == 16'd0) begin
                        state_d      = lastq_q ? ST_HDR : ST_DROP;
                        err_length_d = !lastq_q;
                    end else begin
                        state_d      = lastq_q ? ST_HDR : ST_PAYLOAD;
                        err_length_d = lastq_q;
                    end
                end
            end
            ST_PAYLOAD: begin
                in_rdy_c  = bus.pl_rdy;
                pl_vld_c  = bus.in_vld;
                pl_last_c = bus.in_last | rem_le_b;
                for (int i = 0; i < B; i++) begin
                    pl_keep_c[B-1-i] = (rem_q > 17'(i));
                end
                if (bus.in_vld && bus.pl_rdy) begin
                    rem_d = rem_le_b ? 17'd0 : rem_q - 17'(B);
                    if (rem_le_b) begin
                        state_d      = bus.in_last ? ST_HDR : ST_DROP;
                        err_length_d = !bus.in_last;
                    end else if (bus.in_last) begin
                        state_d      = ST_HDR;
                        err_length_d = 1'b1;
                    end
                end
            end
            default: begin
                in_rdy_c = 1'b1;
                if (bus.in_vld && bus.in_last) begin
                    state_d = ST_HDR;
                end
            end
        endcase

        if (rst) begin
            in_rdy_c = 1'b0;
            pl_vld_c = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_HDR;
            cnt_q         <= '0;
            rem_q         <= '0;
            lastq_q       <= 1'b0;
            hdr_q         <= '0;
            err_version_q <= 1'b0;
            err_length_q  <= 1'b0;
            err_hop_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            lastq_q       <= lastq_d;
            hdr_q         <= hdr_d;
            err_version_q <= err_version_d;
            err_length_q  <= err_length_d;
            err_hop_q     <= err_hop_d;
        end
    end

    assign bus.in_rdy      = in_rdy_c;
    assign bus.hdr_vld     = (state_q == ST_HOLD);
    assign bus.hdr_bus     = hdr_q;
    assign bus.pl_vld      = pl_vld_c;
    assign bus.pl_bus      = bus.in_bus;
    assign bus.pl_keep     = pl_keep_c;
    assign bus.pl_last     = pl_last_c;
    assign bus.err_version = err_version_q;
    assign bus.err_length  = err_length_q;
    assign bus.err_hop     = err_hop_q;
endmodule

// File: tb/tb_ipv6_header_deframer.sv
// Bench for ipv6_header_deframer: directed and random packets checked against a packet-level model.
module tb_ipv6_header_deframer;
    localparam int WD = 32;
    localparam int N  = 10;
    localparam int B  = 4;

    typedef struct packed {
        logic [WD-1:0] data;
        logic [B-1:0]  keep;
        logic          last;
    } pl_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ipv6_header_deframer_if #(.WD(WD)) bus ();
    ipv6_header_deframer #(.WD(WD)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int errors = 0;
    int checks = 0;
    int mode   = 0;

    logic [319:0] obs_hdr[$];
    pl_t          obs_pl[$];
    int           n_ev, n_el, n_eh, hold_viol, hv_cnt;
    logic [319:0] prev_hdr;
    logic         prev_hold = 1'b0;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.err_version) n_ev++;
        if (bus.err_length)  n_el++;
        if (bus.err_hop)     n_eh++;
        if (bus.hdr_vld) begin
            if (bus.in_rdy) hold_viol++;
            if (prev_hold && bus.hdr_bus !== prev_hdr) hold_viol++;
            prev_hdr = bus.hdr_bus;
            if (bus.hdr_rdy) begin
                obs_hdr.push_back(bus.hdr_bus);
                prev_hold = 1'b0;
                hv_cnt    = 0;
            end else begin
                prev_hold = 1'b1;
                hv_cnt++;
            end
        end else begin
            prev_hold = 1'b0;
            hv_cnt    = 0;
        end
        if (bus.pl_vld && bus.pl_rdy)
            obs_pl.push_back('{bus.pl_bus, bus.pl_keep, bus.pl_last});
    end

    task automatic drive_rdy();
        case (mode)
            0: begin bus.hdr_rdy = 1'b1; bus.pl_rdy = 1'b1; end
            1: begin
                bus.hdr_rdy = ($urandom_range(0, 3) != 0);
                bus.pl_rdy  = ($urandom_range(0, 2) != 0);
            end
            default: begin
                bus.pl_rdy  = ~bus.pl_rdy;
                bus.hdr_rdy = (hv_cnt >= 5);
            end
        endcase
    endtask

    task automatic send_beat(input logic [WD-1:0] d, input logic last);
        logic done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(posedge clk); #1;
            drive_rdy();
            bus.in_vld  = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_bus  = d;
            bus.in_last = last;
            @(negedge clk);
            if (bus.in_vld && bus.in_rdy) done = 1'b1;
        end
        check("beat_accept", done, 1'b1);
    endtask

    task automatic idle();
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            drive_rdy();
            bus.in_vld  = 1'b0;
            bus.in_last = 1'b0;
            @(negedge clk);
            if (t >= 2 && !bus.hdr_vld) break;
        end
        check("idle_drain", bus.hdr_vld, 1'b0);
    endtask

    function automatic logic [319:0] make_hdr(input int ver, input int plen, input int hop);
        logic [319:0] h;
        for (int i = 0; i < N; i++) h[319-WD*i -: WD] = $urandom();
        h[319:316] = 4'(ver);
        h[287:272] = 16'(plen);
        h[263:256] = 8'(hop);
        return h;
    endfunction

    // Packet-level expectation: header beats nhdr, payload beats npl following a full header.
    task automatic run_packet(input string name, input logic [319:0] h, input int nhdr, input int npl);
        logic [WD-1:0] pd[$];
        pl_t  exp_pl[$];
        int   exp_hdr_n = 0, exp_v = 0, exp_l = 0, exp_h = 0;
        int   plen, need, k, remain, nb;
        logic hop_chk;
        obs_hdr.delete(); obs_pl.delete();
        n_ev = 0; n_el = 0; n_eh = 0; hold_viol = 0;
        for (int i = 0; i < npl; i++) pd.push_back($urandom());
`ifdef IPV6_DEFRAMER_HOPLIMIT_CHECK_EN
        hop_chk = 1'b1;
`else
        hop_chk = 1'b0;
`endif
        plen = int'(h[287:272]);
        need = (plen + B - 1) / B;
        if (nhdr < N) exp_l = 1;
        else if (h[319:316] != 4'd6) exp_v = 1;
        else if (hop_chk && h[263:256] == 8'd0) exp_h = 1;
        else begin
            exp_hdr_n = 1;
            if (plen == 0) begin
                if (npl > 0) exp_l = 1;
            end else if (npl == 0) exp_l = 1;
            else begin
                k = (npl < need) ? npl : need;
                for (int i = 0; i < k; i++) begin
                    remain = plen - i * B;
                    nb     = (remain < B) ? remain : B;
                    exp_pl.push_back('{pd[i], B'(((1 << nb) - 1) << (B - nb)), (i == k - 1)});
                end
                if (npl != need) exp_l = 1;
            end
        end

        for (int i = 0; i < nhdr; i++)
            send_beat(h[319-WD*i -: WD], (i == nhdr - 1) && (npl == 0));
        for (int i = 0; i < npl; i++)
            send_beat(pd[i], i == npl - 1);
        idle();

        check({name, ".hdr_count"}, obs_hdr.size(), exp_hdr_n);
        if (obs_hdr.size() > 0 && exp_hdr_n > 0) check({name, ".hdr_bus"}, obs_hdr[0], h);
        check({name, ".pl_count"}, obs_pl.size(), exp_pl.size());
        for (int i = 0; i < exp_pl.size() && i < obs_pl.size(); i++)
            check($sformatf("%s.pl%0d", name, i), obs_pl[i], exp_pl[i]);
        check({name, ".err_version"}, n_ev, exp_v);
        check({name, ".err_length"}, n_el, exp_l);
        check({name, ".err_hop"}, n_eh, exp_h);
        check({name, ".hold"}, hold_viol, 0);
    endtask

    initial begin
        logic [319:0] h;
        int ver, plen, hop, nhdr, npl, need;
        rst = 1'b1;
        bus.in_vld = 1'b1; bus.in_bus = '0; bus.in_last = 1'b0;
        bus.hdr_rdy = 1'b1; bus.pl_rdy = 1'b0;
        @(negedge clk);
        check("rst.hdr_vld", bus.hdr_vld, 1'b0);
        check("rst.hdr_bus", bus.hdr_bus, 320'd0);
        check("rst.in_rdy", bus.in_rdy, 1'b0);
        check("rst.pl_vld", bus.pl_vld, 1'b0);
        check("rst.errs", {bus.err_version, bus.err_length, bus.err_hop}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0; bus.in_vld = 1'b0;

        run_packet("basic", make_hdr(6, 6, 64), N, 2);
        mode = 2;
        run_packet("backpressure", make_hdr(6, 6, 64), N, 2);
        mode = 0;
        run_packet("bad_version", make_hdr(4, 6, 64), N, 3);
        run_packet("after_version", make_hdr(6, 5, 10), N, 2);
        run_packet("short_hdr", make_hdr(6, 0, 10), 5, 0);
        run_packet("zero_len", make_hdr(6, 0, 10), N, 0);
        run_packet("extra_beat", make_hdr(6, 8, 10), N, 3);
        run_packet("short_pl", make_hdr(6, 12, 10), N, 2);
        run_packet("hop_zero", make_hdr(6, 4, 0), N, 1);
        run_packet("len_no_pl", make_hdr(6, 4, 9), N, 0);
        run_packet("zero_len_extra", make_hdr(6, 0, 9), N, 1);

        h = make_hdr(6, 3, 1);
        for (int i = 0; i < 3; i++) send_beat(h[319-WD*i -: WD], 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; bus.in_vld = 1'b1;
        @(negedge clk);
        check("midrst.in_rdy", bus.in_rdy, 1'b0);
        check("midrst.pl_vld", bus.pl_vld, 1'b0);
        check("midrst.hdr_vld", bus.hdr_vld, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; bus.in_vld = 1'b0;
        run_packet("after_rst", make_hdr(6, 7, 3), N, 2);

        mode = 1;
        for (int p = 0; p < 40; p++) begin
            ver  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 5)) : 6;
            plen = $urandom_range(0, 20);
            hop  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            nhdr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, N - 1)) : N;
            need = (plen + B - 1) / B;
            npl  = need + int'($urandom_range(0, 2)) - 1;
            if (npl < 0 || nhdr < N) npl = 0;
            run_packet($sformatf("rand%0d", p), make_hdr(ver, plen, hop), nhdr, npl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
